// File: rtl/csdf_flux_scheduler.sv
// csdf_flux_scheduler: round-robin, burst-atomic scheduler for the shared CSDF accumulate datapath.
module csdf_flux_scheduler #(
    parameter int FLUX = 2,
    parameter int PORTS = 2,
    parameter int NUM_OP = 4,
    localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1,
    localparam int CNT_WIDTH = (NUM_OP > 1) ? $clog2(NUM_OP) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS*FLUX-1:0]  empty,
    input  logic [FLUX-1:0]        full,
    output logic [PORTS*FLUX-1:0]  read,
    output logic                   acc_load,
    output logic                   acc_en,
    output logic                   write,
    output logic [TAG_WIDTH-1:0]   sel,
    output logic [CNT_WIDTH-1:0]   remaining,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(NUM_OP - 1);
    localparam int TAGS = 1 << TAG_WIDTH;
    state_t state, state_d;
    logic [TAG_WIDTH-1:0] sel_d, rr_ptr, rr_d, pick;
    logic [CNT_WIDTH-1:0] rem_d;
    logic [TAGS-1:0] ready, full_p;
    logic hit, sel_ready;
    // Padded to the full tag range so unused tag codes read as not-ready / full.
    always_comb begin
        ready = '0;
        full_p = '1;
        for (int f = 0; f < FLUX; f++) begin
            ready[f] = ~|empty[f*PORTS +: PORTS];
            full_p[f] = full[f];
        end
        sel_ready = ready[sel];
    end
    // Scan downward so the smallest offset from rr_ptr is the one that sticks.
    always_comb begin
        hit = 1'b0;
        pick = '0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            if (ready[(int'(rr_ptr) + i) % FLUX]) begin
                hit = 1'b1;
                pick = TAG_WIDTH'((int'(rr_ptr) + i) % FLUX);
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sel <= '0;
            rr_ptr <= '0;
            remaining <= LAST;
        end else begin
            state <= state_d;
            sel <= sel_d;
            rr_ptr <= rr_d;
            remaining <= rem_d;
        end
    end
    always_comb begin
        state_d = state;
        sel_d = sel;
        rem_d = remaining;
        rr_d = rr_ptr;
        case (state)
            IDLE: if (hit) begin
                state_d = ACCUM;
                sel_d = pick;
                rem_d = LAST;
            end
            ACCUM: if (sel_ready) begin
                if (remaining == '0) state_d = EMIT;
                else rem_d = remaining - 1'b1;
            end
            EMIT: if (!full_p[sel]) begin
                state_d = IDLE;
                rr_d = (sel == TAG_WIDTH'(FLUX - 1)) ? '0 : sel + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        read = '0;
        acc_en = state == ACCUM && sel_ready;
        if (acc_en) read[sel*PORTS +: PORTS] = '1;
        acc_load = acc_en && remaining == LAST;
        write = state == EMIT && !full_p[sel];
        busy = state != IDLE;
    end
endmodule

// File: tb/tb_csdf_flux_scheduler.sv
// tb_csdf_flux_scheduler: per-cycle vector tables for FLUX=2/NUM_OP=4, plus reset and FLUX=1/NUM_OP=1 sequences.
module tb_csdf_flux_scheduler;
    typedef struct {
        logic [3:0] empty;
        logic [1:0] full;
        logic [3:0] read;
        logic       ld;
        logic       en;
        logic       wr;
        logic       bz;
        logic       sl;
        logic [1:0] rm;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] empty = 4'b0000;
    logic [1:0] full = 2'b00;
    logic [3:0] read;
    logic acc_load, acc_en, write, busy, sel;
    logic [1:0] remaining;
    logic [1:0] empty1 = 2'b00;
    logic [0:0] full1 = 1'b0;
    logic [1:0] read1;
    logic acc_load1, acc_en1, write1, busy1;
    logic [0:0] sel1, remaining1;
    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    csdf_flux_scheduler #(.FLUX(2), .PORTS(2), .NUM_OP(4)) dut (
        .clk(clk), .rst(rst), .empty(empty), .full(full), .read(read),
        .acc_load(acc_load), .acc_en(acc_en), .write(write), .sel(sel),
        .remaining(remaining), .busy(busy)
    );

    csdf_flux_scheduler #(.FLUX(1), .PORTS(2), .NUM_OP(1)) dut1 (
        .clk(clk), .rst(rst), .empty(empty1), .full(full1), .read(read1),
        .acc_load(acc_load1), .acc_en(acc_en1), .write(write1), .sel(sel1),
        .remaining(remaining1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] e, input logic [1:0] f, input logic [3:0] rd,
                       input logic ld, input logic en, input logic wr, input logic bz,
                       input logic sl, input logic [1:0] rm);
        vec_t v;
        v.empty = e; v.full = f; v.read = rd; v.ld = ld; v.en = en;
        v.wr = wr; v.bz = bz; v.sl = sl; v.rm = rm;
        vecs.push_back(v);
    endtask

    // Holds reset across one rising edge and releases it on the falling edge that starts cycle 0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst read", 32'(read), 0);
        chk("rst strobes", 32'({acc_load, acc_en, write}), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst sel", 32'(sel), 0);
        chk("rst remaining", 32'(remaining), 3);
        chk("rst1 write", 32'(write1), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_vecs(input string tag);
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            empty = vecs[i].empty;
            full = vecs[i].full;
            exp_q.push_back(vecs[i]);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("%s[%0d] read", tag, i), 32'(read), 32'(e.read));
            chk($sformatf("%s[%0d] acc_load", tag, i), 32'(acc_load), 32'(e.ld));
            chk($sformatf("%s[%0d] acc_en", tag, i), 32'(acc_en), 32'(e.en));
            chk($sformatf("%s[%0d] write", tag, i), 32'(write), 32'(e.wr));
            chk($sformatf("%s[%0d] busy", tag, i), 32'(busy), 32'(e.bz));
            chk($sformatf("%s[%0d] sel", tag, i), 32'(sel), 32'(e.sl));
            chk($sformatf("%s[%0d] remaining", tag, i), 32'(remaining), 32'(e.rm));
            @(negedge clk);
        end
        vecs.delete();
    endtask

    initial begin
        // Both fluxes always ready: bursts alternate 0,1,0 with a 6-cycle period.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            logic s;
            s = 1'(b % 2);
            add(4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, (b == 0) ? 1'b0 : ~s, (b == 0) ? 2'd3 : 2'd0);
            for (int k = 0; k < 4; k++)
                add(4'b0000, 2'b00, s ? 4'b1100 : 4'b0011, k == 0, 1, 0, 1, s, 2'(3 - k));
            add(4'b0000, 2'b00, 4'b0000, 0, 0, 1, 1, s, 2'd0);
        end
        run_vecs("alt");

        // Only flux 1 ready; after its write rr_ptr wraps to 0 and flux 0 wins.
        do_reset();
        add(4'b0011, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 2'd3);
        for (int k = 0; k < 4; k++) add(4'b0011, 2'b00, 4'b1100, k == 0, 1, 0, 1, 1, 2'(3 - k));
        add(4'b0011, 2'b00, 4'b0000, 0, 0, 1, 1, 1, 2'd0);
        add(4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 2'd0);
        add(4'b0000, 2'b00, 4'b0011, 1, 1, 0, 1, 0, 2'd3);
        run_vecs("only1");

        // Port 1 of flux 0 goes empty for burst cycles 2-3: reads stall, remaining frozen.
        do_reset();
        add(4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 2'd3);
        add(4'b0000, 2'b00, 4'b0011, 1, 1, 0, 1, 0, 2'd3);
        add(4'b0010, 2'b00, 4'b0000, 0, 0, 0, 1, 0, 2'd2);
        add(4'b0010, 2'b00, 4'b0000, 0, 0, 0, 1, 0, 2'd2);
        add(4'b0000, 2'b00, 4'b0011, 0, 1, 0, 1, 0, 2'd2);
        add(4'b0000, 2'b00, 4'b0011, 0, 1, 0, 1, 0, 2'd1);
        add(4'b0000, 2'b00, 4'b0011, 0, 1, 0, 1, 0, 2'd0);
        add(4'b0000, 2'b00, 4'b0000, 0, 0, 1, 1, 0, 2'd0);
        add(4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 2'd0);
        add(4'b0000, 2'b00, 4'b1100, 1, 1, 0, 1, 1, 2'd3);
        run_vecs("stall");

        // full[0] held for 5 EMIT cycles while flux 1 inputs toggle; write when full[0] drops.
        do_reset();
        add(4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 2'd3);
        for (int k = 0; k < 4; k++) add(4'b0000, 2'b00, 4'b0011, k == 0, 1, 0, 1, 0, 2'(3 - k));
        for (int k = 0; k < 5; k++)
            add(k[0] ? 4'b1100 : 4'b0000, k[0] ? 2'b11 : 2'b01, 4'b0000, 0, 0, 0, 1, 0, 2'd0);
        add(4'b0000, 2'b10, 4'b0000, 0, 0, 1, 1, 0, 2'd0);
        add(4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 2'd0);
        add(4'b0000, 2'b00, 4'b1100, 1, 1, 0, 1, 1, 2'd3);
        run_vecs("full");

        // Asynchronous reset mid-ACCUM with remaining=1.
        do_reset();
        empty = 4'b0000;
        full = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        chk("mid pre remaining", 32'(remaining), 1);
        chk("mid pre read", 32'(read), 32'b0011);
        #2 rst = 1'b0;
        #1;
        chk("mid read", 32'(read), 0);
        chk("mid strobes", 32'({acc_load, acc_en, write}), 0);
        chk("mid busy", 32'(busy), 0);
        chk("mid remaining", 32'(remaining), 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid idle busy", 32'(busy), 0);
        @(negedge clk);
        #1;
        chk("mid restart acc_load", 32'(acc_load), 1);
        chk("mid restart remaining", 32'(remaining), 3);
        chk("mid restart read", 32'(read), 32'b0011);

        // FLUX=1, NUM_OP=1: IDLE, ACCUM, EMIT repeating; write every third cycle.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            #1;
            chk($sformatf("n1[%0d] read", c), 32'(read1), (c % 3 == 1) ? 32'b11 : 32'b0);
            chk($sformatf("n1[%0d] load_en", c), 32'({acc_load1, acc_en1}), (c % 3 == 1) ? 32'b11 : 32'b0);
            chk($sformatf("n1[%0d] write", c), 32'(write1), (c % 3 == 2) ? 32'd1 : 32'd0);
            chk($sformatf("n1[%0d] busy", c), 32'(busy1), (c % 3 != 0) ? 32'd1 : 32'd0);
            chk($sformatf("n1[%0d] sel", c), 32'(sel1), 0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
